// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, a decode holding register
// and a one-entry skid buffer, with flush redirect and misaligned-PC detection.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic        PC_EN,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_D,
    output logic [31:0] PC4_D,
    output logic        valid_D,
    input  logic        stall_D,
    output logic        adel_D
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        drop_r;
    logic        drop_s;

    logic        valid_r;
    logic [31:0] ir_r;
    logic [31:0] pc4_r;
    logic        adel_r;
    logic        skid_vld_r;
    logic [31:0] skid_ir_r;
    logic [31:0] skid_pc4_r;
    logic        skid_adel_r;

    logic        xfer_s;
    logic        out_free_s;
    logic        slot_free_s;
    logic        misal_s;
    logic        acc_s;
    logic [31:0] acc_ir_s;
    logic        acc_adel_s;
    logic        pc_en_s;
    logic        req_s;
    logic        valid_nxt_s;
    logic        skid_nxt_s;

    assign xfer_s      = valid_r & ~stall_D;
    assign out_free_s  = ~valid_r | xfer_s;
    assign slot_free_s = out_free_s | ~skid_vld_r;
    assign misal_s     = (PC[1:0] != 2'b00);

    // State register and drop flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_REQ;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            drop_r  <= drop_s;
        end
    end

    // Output decode: request, PC enable and the word accepted this cycle
    always_comb begin
        acc_s      = 1'b0;
        acc_ir_s   = 32'h0000_0000;
        acc_adel_s = 1'b0;
        pc_en_s    = 1'b0;
        req_s      = 1'b0;
        case (state_r)
            S_REQ: begin
                if (flush) begin
                    pc_en_s = 1'b1;
                end else if (slot_free_s && misal_s) begin
                    acc_s      = 1'b1;
                    acc_adel_s = 1'b1;
                    pc_en_s    = 1'b1;
                end else if (slot_free_s) begin
                    req_s = 1'b1;
                end else begin
                    req_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_en_s = 1'b1;
                end else if (imem_rvalid && !drop_r) begin
                    acc_s    = 1'b1;
                    acc_ir_s = imem_rdata;
                    pc_en_s  = 1'b1;
                end else begin
                    pc_en_s = 1'b0;
                end
            end
            S_FULL: begin
                if (flush) begin
                    pc_en_s = 1'b1;
                end else begin
                    pc_en_s = 1'b0;
                end
            end
            default: begin
                pc_en_s = 1'b0;
            end
        endcase
    end

    // Occupancy of output register and skid buffer after this edge
    always_comb begin
        valid_nxt_s = 1'b0;
        skid_nxt_s  = 1'b0;
        if (flush) begin
            valid_nxt_s = 1'b0;
            skid_nxt_s  = 1'b0;
        end else if (out_free_s) begin
            valid_nxt_s = skid_vld_r | acc_s;
            skid_nxt_s  = skid_vld_r & acc_s;
        end else begin
            valid_nxt_s = 1'b1;
            skid_nxt_s  = skid_vld_r | acc_s;
        end
    end

    // Next-state logic; a flush with no response pending marks the in-flight word for discard
    always_comb begin
        state_s = state_r;
        drop_s  = drop_r;
        case (state_r)
            S_REQ: begin
                if (req_s) begin
                    state_s = S_WAIT;
                end else if (valid_nxt_s && skid_nxt_s) begin
                    state_s = S_FULL;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_s  = 1'b0;
                    state_s = (valid_nxt_s && skid_nxt_s) ? S_FULL : S_REQ;
                end else if (flush) begin
                    drop_s  = 1'b1;
                    state_s = S_WAIT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_FULL: begin
                if (valid_nxt_s && skid_nxt_s) begin
                    state_s = S_FULL;
                end else begin
                    state_s = S_REQ;
                end
            end
            default: begin
                state_s = S_REQ;
                drop_s  = 1'b0;
            end
        endcase
    end

    // Decode holding register and skid buffer; the skid entry always drains first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r     <= 1'b0;
            ir_r        <= 32'h0000_0000;
            pc4_r       <= RESET_PC;
            adel_r      <= 1'b0;
            skid_vld_r  <= 1'b0;
            skid_ir_r   <= 32'h0000_0000;
            skid_pc4_r  <= 32'h0000_0000;
            skid_adel_r <= 1'b0;
        end else if (flush) begin
            valid_r    <= 1'b0;
            skid_vld_r <= 1'b0;
        end else if (out_free_s) begin
            if (skid_vld_r) begin
                valid_r    <= 1'b1;
                ir_r       <= skid_ir_r;
                pc4_r      <= skid_pc4_r;
                adel_r     <= skid_adel_r;
                skid_vld_r <= acc_s;
                if (acc_s) begin
                    skid_ir_r   <= acc_ir_s;
                    skid_pc4_r  <= PC + 32'd4;
                    skid_adel_r <= acc_adel_s;
                end
            end else if (acc_s) begin
                valid_r <= 1'b1;
                ir_r    <= acc_ir_s;
                pc4_r   <= PC + 32'd4;
                adel_r  <= acc_adel_s;
            end else begin
                valid_r <= 1'b0;
            end
        end else if (acc_s) begin
            skid_vld_r  <= 1'b1;
            skid_ir_r   <= acc_ir_s;
            skid_pc4_r  <= PC + 32'd4;
            skid_adel_r <= acc_adel_s;
        end
    end

    assign PC_EN     = pc_en_s & reset;
    assign imem_req  = req_s & reset;
    assign imem_addr = PC;
    assign IR_D      = ir_r;
    assign PC4_D     = pc4_r;
    assign valid_D   = valid_r;
    assign adel_D    = adel_r;

endmodule
